// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : MEM stage for the two-slot pipeline. Byte load/store over a
//            req/ack data-memory handshake, with timeout fault and the MEM/WB
//            register. Optional macro SIGN_EXTEND_LOAD_EN sign-extends loads.
// Revision : 1.0
// ============================================================================
module mem_stage #(
    parameter int DMEM_AW = 8,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p3_memRead,
    input  logic               p3_memWrite,
    input  logic               p3_alu_regWrite,
    input  logic               p3_mem_regWrite,
    input  logic [2:0]         p3_alu_rd,
    input  logic [2:0]         p3_mem_rd,
    input  logic [7:0]         p3_mem_reg_rd,
    input  logic [31:0]        p3_alu_aluOut,
    input  logic [31:0]        p3_mem_address,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [7:0]         dmem_wdata,
    input  logic [7:0]         dmem_rdata,
    input  logic               dmem_ack,
    output logic               mem_stall,
    output logic               mem_fault,
    output logic               p4_alu_regWrite,
    output logic               p4_mem_regWrite,
    output logic [2:0]         p4_alu_rd,
    output logic [2:0]         p4_mem_rd,
    output logic [31:0]        p4_alu_result,
    output logic [31:0]        p4_mem_data
);

    localparam logic [7:0] c_timeout_cnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic               r_fault;
    logic               r_h_we;
    logic               r_h_load;
    logic [DMEM_AW-1:0] r_h_addr;
    logic [7:0]         r_h_wdata;
    logic               r_h_alu_regWrite;
    logic               r_h_mem_regWrite;
    logic [2:0]         r_h_alu_rd;
    logic [2:0]         r_h_mem_rd;
    logic [31:0]        r_h_alu_result;

    logic               w_access;
    logic               w_oor;
    logic               w_load;
    logic [31:0]        w_load_data;

    assign w_access  = p3_memRead | p3_memWrite;
    assign w_oor     = w_access & (p3_mem_address[31:DMEM_AW] != '0);
    assign w_load    = p3_memRead & ~p3_memWrite;
    assign mem_fault = r_fault;

`ifdef SIGN_EXTEND_LOAD_EN
    assign w_load_data = {{24{dmem_rdata[7]}}, dmem_rdata};
`else
    assign w_load_data = {24'b0, dmem_rdata};
`endif

    // IDLE forwards the EX/MEM request straight to memory for zero-latency completion
    always_comb begin
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        mem_stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                dmem_req   = w_access & ~w_oor;
                dmem_we    = p3_memWrite;
                dmem_addr  = p3_mem_address[DMEM_AW-1:0];
                dmem_wdata = p3_mem_reg_rd;
                mem_stall  = w_access & ~w_oor & ~dmem_ack;
            end
            S_WAIT: begin
                dmem_req   = 1'b1;
                dmem_we    = r_h_we;
                dmem_addr  = r_h_addr;
                dmem_wdata = r_h_wdata;
                mem_stall  = ~dmem_ack;
            end
            default: mem_stall = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_oor) begin
                        r_fault <= 1'b1;
                    end
                    if (w_access & ~w_oor & ~dmem_ack) begin
                        r_state          <= S_WAIT;
                        r_cnt            <= 8'd1;
                        r_h_we           <= p3_memWrite;
                        r_h_load         <= w_load;
                        r_h_addr         <= p3_mem_address[DMEM_AW-1:0];
                        r_h_wdata        <= p3_mem_reg_rd;
                        r_h_alu_regWrite <= p3_alu_regWrite;
                        r_h_mem_regWrite <= p3_mem_regWrite & w_load;
                        r_h_alu_rd       <= p3_alu_rd;
                        r_h_mem_rd       <= p3_mem_rd;
                        r_h_alu_result   <= p3_alu_aluOut;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == c_timeout_cnt) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_fault <= 1'b1;
            endcase
        end
    end

    // MEM/WB: bubble while stalled; FAULT always stalls so only IDLE/WAIT capture
    always_ff @(posedge clk) begin
        if (reset) begin
            p4_alu_regWrite <= 1'b0;
            p4_mem_regWrite <= 1'b0;
            p4_alu_rd       <= 3'd0;
            p4_mem_rd       <= 3'd0;
            p4_alu_result   <= 32'd0;
            p4_mem_data     <= 32'd0;
        end else if (mem_stall) begin
            p4_alu_regWrite <= 1'b0;
            p4_mem_regWrite <= 1'b0;
        end else if (r_state == S_WAIT) begin
            p4_alu_regWrite <= r_h_alu_regWrite;
            p4_mem_regWrite <= r_h_mem_regWrite;
            p4_alu_rd       <= r_h_alu_rd;
            p4_mem_rd       <= r_h_mem_rd;
            p4_alu_result   <= r_h_alu_result;
            if (r_h_load) begin
                p4_mem_data <= w_load_data;
            end
        end else begin
            p4_alu_regWrite <= p3_alu_regWrite;
            p4_mem_regWrite <= p3_mem_regWrite & w_load & ~w_oor;
            p4_alu_rd       <= p3_alu_rd;
            p4_mem_rd       <= p3_mem_rd;
            p4_alu_result   <= p3_alu_aluOut;
            if (w_load) begin
                p4_mem_data <= w_oor ? 32'd0 : w_load_data;
            end
        end
    end

endmodule
`default_nettype wire
